dmem_responder: RTL

//  Responder side of the MEM-stage data-memory interface: accepts one load/store request at a time

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/dmem_sram_array.sv | 28 ++
 rtl/dmem_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
// Holds the FSM state encoding, the byte-to-word offset and the index-width helper.
// No logic of its own.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte address bits below the word index (32-bit words).
  localparam int WORD_OFFSET = 2;

  // Number of index bits needed to address a storage array of the given depth.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Purpose: single-port word storage, synchronous write and synchronous read, not reset.
// Latency: write lands at the clock edge; rdata shows mem[idx] as of the previous edge.
// Backpressure: none, accepts one access every cycle.
module dmem_sram_array
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed word when enabled and register the read of the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: MEM-stage data-memory responder; one load/store at a time against dmem_sram_array.
// Latency: response pulse LATENCY+1 cycles after the accept cycle; optional DMEM_ALIGN_CHECK_EN flags misaligned accesses.
// Backpressure: o_ReqReady only in IDLE; o_StallM holds the pipeline from accept until the response cycle.
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int LATENCY       = 2
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_n,
  input  logic                     i_ReqValid,
  input  logic                     i_ReqWrite,
  input  logic [ADDRESS_WIDTH-1:0] i_ReqAddr,
  input  logic [DATA_WIDTH-1:0]    i_ReqWData,
  output logic                     o_ReqReady,
  output logic                     o_RespValid,
  output logic [DATA_WIDTH-1:0]    o_RespRData,
  output logic                     o_StallM,
  output logic                     o_AddrErr
);

  localparam int IDX_W = idx_width(MEM_DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  cap_write;
  logic [IDX_W-1:0]      cap_idx;
  logic [1:0]            cap_lsb;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      sram_idx;
  logic                  sram_we;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic                  commit;
  logic                  misaligned;

  // Upper address bits alias onto the array; only the word index is used.
  assign req_idx = i_ReqAddr[IDX_W+WORD_OFFSET-1:WORD_OFFSET];

  generate
    if (ADDRESS_WIDTH > IDX_W + WORD_OFFSET) begin : g_alias
      logic unused_upper_addr;
      assign unused_upper_addr = ^i_ReqAddr[ADDRESS_WIDTH-1:IDX_W+WORD_OFFSET];
    end
  endgenerate

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (cap_lsb != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^cap_lsb;
  assign misaligned = 1'b0;
`endif

  // The final WAIT edge commits the store or registers the load data.
  assign commit   = (state == WAIT) && (cnt == '0);
  assign sram_we  = commit && cap_write && !misaligned;
  // In IDLE the array already reads the incoming word so data is ready even for LATENCY=1.
  assign sram_idx = (state == IDLE) ? req_idx : cap_idx;

  assign o_ReqReady = (state == IDLE);
  assign o_StallM   = ((state == IDLE) && i_ReqValid) || (state == WAIT);

  dmem_sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (i_CLK),
    .we   (sram_we),
    .idx  (sram_idx),
    .wdata(cap_wdata),
    .rdata(sram_rdata)
  );

  // Request FSM: capture in IDLE, count down in WAIT, single response pulse in RESP.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_write   <= 1'b0;
      cap_idx     <= '0;
      cap_lsb     <= 2'b00;
      cap_wdata   <= '0;
      o_RespValid <= 1'b0;
      o_RespRData <= '0;
      o_AddrErr   <= 1'b0;
    end else begin
      o_RespValid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_ReqValid) begin
            cap_write <= i_ReqWrite;
            cap_idx   <= req_idx;
            cap_lsb   <= i_ReqAddr[1:0];
            cap_wdata <= i_ReqWData;
            cnt       <= CNT_LOAD;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            o_RespValid <= 1'b1;
            o_AddrErr   <= misaligned;
            o_RespRData <= (cap_write || misaligned) ? '0 : sram_rdata;
            state       <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
